// File: rtl/trig_capture_if.sv
// Head-of-queue handshake between trig_capture and its event consumer.
// The master side presents the stamp; the slave side accepts it.
interface trig_capture_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_stamp;

    modport master (output out_valid, output out_stamp, input out_ready);
    modport slave  (input out_valid, input out_stamp, output out_ready);
endinterface

// File: rtl/trig_capture.sv
// Timestamps pulses on one selected trigger bit with the counter value and
// queues them in a small FIFO with overflow/drop reporting.
module trig_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           trig_in,
    input  logic [WIDTH-1:0]           count_in,
    input  logic [$clog2(WIDTH)-1:0]   sel,
    input  logic                       arm,
    trig_capture_if.master             out_bus,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       ovf,
    output logic [WIDTH-1:0]           drop_cnt,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             sel_ok;
    logic             event_hit;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Only a non-power-of-two WIDTH leaves sel codes that name no bit.
    generate
        if ((2 ** SW) > WIDTH) begin : g_sel_range
            assign sel_ok = (int'(sel) < WIDTH);
        end else begin : g_sel_full
            assign sel_ok = 1'b1;
        end
    endgenerate

    assign event_hit = arm & sel_ok & trig_in[sel];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop       = ~empty & out_bus.out_ready;
    // A pop on a full FIFO frees the slot the same-cycle push uses.
    assign push      = event_hit & (~full | pop);
    assign drop      = event_hit & full & ~pop;

    assign out_bus.out_valid = ~empty;
    assign out_bus.out_stamp = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fill              = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= count_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule
